// File: rtl/cursor_overlay_pkg.sv
// Shared constants, FSM encodings and ROM address helper
// for the hardware mouse-cursor overlay.
package cursor_overlay_pkg;

  localparam int CURSOR_SIZE     = 16;
  localparam int WORDS_PER_ROW   = 2;
  localparam int WORDS_PER_SHAPE = 32;

  localparam logic [1:0] CODE_TRANSPARENT = 2'b00;
  localparam logic [1:0] CODE_FG          = 2'b01;
  localparam logic [1:0] CODE_BG          = 2'b10;
  localparam logic [1:0] CODE_INVERT      = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE        = 3'd0;
  localparam state_t ST_REQ_HI      = 3'd1;
  localparam state_t ST_REQ_LO      = 3'd2;
  localparam state_t ST_CAP_LO      = 3'd3;
  localparam state_t ST_COMMIT_WAIT = 3'd4;

  // shape*32 + row*2 + half
  function automatic logic [8:0] rom_addr(
    input logic [3:0] shape,
    input logic [3:0] row,
    input logic       half
  );
    return {shape, row, half};
  endfunction

endpackage

// File: rtl/cursor_line_buffer.sv
// Shadow/live 32-bit row double buffer with the
// registered per-pixel code select.
module cursor_line_buffer
  import cursor_overlay_pkg::*;
#(
  parameter int X_WIDTH = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cap_hi,
  input  logic               cap_lo,
  input  logic               shadow_clear,
  input  logic               commit,
  input  logic               live_clear,
  input  logic [15:0]        rom_data,
  input  logic               pixel_active,
  input  logic [X_WIDTH-1:0] xpos,
  input  logic [X_WIDTH-1:0] cursor_x,
  output logic               cursor_on,
  output logic [1:0]         cursor_code
);

  logic [31:0]      shadow;
  logic [31:0]      live;
  logic             shadow_valid;
  logic             live_valid;
  logic [31:0]      sel_data;
  logic             sel_valid;
  logic [X_WIDTH:0] dx;
  logic [31:0]      shifted;
  logic             hit;
  logic [1:0]       code_next;

  // The commit cycle already renders from the new row.
  always_comb begin
    sel_data  = live;
    sel_valid = live_valid;
    if (commit && !live_clear) begin
      sel_data  = shadow;
      sel_valid = shadow_valid;
    end
    dx = {1'b0, xpos} - {1'b0, cursor_x};
    hit = pixel_active && sel_valid &&
          (xpos >= cursor_x) &&
          (dx < (X_WIDTH+1)'(CURSOR_SIZE));
    shifted = sel_data << {dx[3:0], 1'b0};
    code_next = hit ? shifted[31:30] : CODE_TRANSPARENT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow       <= '0;
      live         <= '0;
      shadow_valid <= 1'b0;
      live_valid   <= 1'b0;
      cursor_code  <= CODE_TRANSPARENT;
      cursor_on    <= 1'b0;
    end else begin
      if (shadow_clear)
        shadow_valid <= 1'b0;
      if (cap_hi)
        shadow[31:16] <= rom_data;
      if (cap_lo) begin
        shadow[15:0] <= rom_data;
        shadow_valid <= 1'b1;
      end
      if (live_clear) begin
        live       <= '0;
        live_valid <= 1'b0;
      end else if (commit) begin
        live       <= shadow;
        live_valid <= shadow_valid;
      end
      cursor_code <= code_next;
      cursor_on   <= (code_next != CODE_TRANSPARENT);
    end
  end

endmodule

// File: rtl/cursor_overlay.sv
// Cursor renderer: per-frame latch, blanking-time ROM
// fetch FSM and line buffer driving the colour mixer.
module cursor_overlay
  import cursor_overlay_pkg::*;
#(
  parameter int X_WIDTH     = 11,
  parameter int Y_WIDTH     = 10,
  parameter int SHAPE_COUNT = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic [X_WIDTH-1:0] xpos,
  input  logic [Y_WIDTH-1:0] ypos,
  input  logic               pixel_active,
  input  logic [X_WIDTH-1:0] cursor_x,
  input  logic [Y_WIDTH-1:0] cursor_y,
  input  logic [3:0]         cursor_shape,
  input  logic               cursor_visible,
  output logic [8:0]         rom_address,
  input  logic [15:0]        rom_data,
  output logic               cursor_on,
  output logic [1:0]         cursor_code
);

  state_t             state;
  logic [X_WIDTH-1:0] lat_x;
  logic [Y_WIDTH-1:0] lat_y;
  logic [3:0]         lat_shape;
  logic               lat_visible;

  logic [Y_WIDTH:0]   target;
  logic [Y_WIDTH:0]   y_end;
  logic [Y_WIDTH:0]   row_full;
  logic               vhit;
  logic               cap_hi;
  logic               cap_lo;
  logic               commit;

  // Extra bit keeps bottom-edge cursors clipping, not wrapping.
  always_comb begin
    target   = {1'b0, ypos} + (Y_WIDTH+1)'(1);
    y_end    = {1'b0, lat_y} + (Y_WIDTH+1)'(CURSOR_SIZE);
    row_full = target - {1'b0, lat_y};
    vhit = lat_visible &&
           ({1'b0, lat_shape} < 5'(SHAPE_COUNT)) &&
           (target >= {1'b0, lat_y}) &&
           (target < y_end);
    cap_hi = (state == ST_REQ_LO) && !line_start;
    cap_lo = (state == ST_CAP_LO) && !line_start;
    commit = (state == ST_COMMIT_WAIT) &&
             pixel_active && !line_start;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      rom_address <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      lat_shape   <= '0;
      lat_visible <= 1'b0;
    end else begin
      if (frame_start) begin
        lat_x       <= cursor_x;
        lat_y       <= cursor_y;
        lat_shape   <= cursor_shape;
        lat_visible <= cursor_visible;
      end
      // A new line_start always restarts the fetch.
      if (line_start) begin
        if (vhit) begin
          state       <= ST_REQ_HI;
          rom_address <= rom_addr(lat_shape, row_full[3:0], 1'b0);
        end else begin
          state <= ST_COMMIT_WAIT;
        end
      end else begin
        unique case (state)
          ST_IDLE: state <= ST_IDLE;
          ST_REQ_HI: begin
            rom_address <= {rom_address[8:1], 1'b1};
            state       <= ST_REQ_LO;
          end
          ST_REQ_LO: state <= ST_CAP_LO;
          ST_CAP_LO: state <= ST_COMMIT_WAIT;
          ST_COMMIT_WAIT:
            if (pixel_active)
              state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  cursor_line_buffer #(
    .X_WIDTH(X_WIDTH)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .cap_hi      (cap_hi),
    .cap_lo      (cap_lo),
    .shadow_clear(line_start),
    .commit      (commit),
    .live_clear  (frame_start),
    .rom_data    (rom_data),
    .pixel_active(pixel_active),
    .xpos        (xpos),
    .cursor_x    (lat_x),
    .cursor_on   (cursor_on),
    .cursor_code (cursor_code)
  );

endmodule

// File: tb/tb_cursor_overlay.sv
// Directed bench for cursor_overlay with a behavioural
// ROM returning 16'hA000 + address one cycle later.
module tb_cursor_overlay;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        line_start;
  logic [10:0] xpos;
  logic [9:0]  ypos;
  logic        pixel_active;
  logic [10:0] cursor_x;
  logic [9:0]  cursor_y;
  logic [3:0]  cursor_shape;
  logic        cursor_visible;
  logic [8:0]  rom_address;
  logic [15:0] rom_data;
  logic        cursor_on;
  logic [1:0]  cursor_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    rom_data <= 16'hA000 + {7'd0, rom_address};

  cursor_overlay dut (
    .clk           (clk),
    .reset         (reset),
    .frame_start   (frame_start),
    .line_start    (line_start),
    .xpos          (xpos),
    .ypos          (ypos),
    .pixel_active  (pixel_active),
    .cursor_x      (cursor_x),
    .cursor_y      (cursor_y),
    .cursor_shape  (cursor_shape),
    .cursor_visible(cursor_visible),
    .rom_address   (rom_address),
    .rom_data      (rom_data),
    .cursor_on     (cursor_on),
    .cursor_code   (cursor_code)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame(input logic [10:0] x,
                           input logic [9:0] y,
                           input logic [3:0] shape,
                           input logic vis);
    cursor_x       = x;
    cursor_y       = y;
    cursor_shape   = shape;
    cursor_visible = vis;
    frame_start    = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  function automatic logic [1:0] exp_code(input int x,
                                          input logic [31:0] w,
                                          input int cx);
    logic [31:0] t;
    if (x < cx || x >= cx + 16) return 2'b00;
    t = w >> (30 - 2 * (x - cx));
    return t[1:0];
  endfunction

  task automatic sweep(input int lo, input int hi,
                       input logic [31:0] w, input logic vld);
    logic [1:0] e;
    for (int x = lo; x <= hi; x++) begin
      xpos = 11'(x);
      pixel_active = 1'b1;
      tick();
      e = vld ? exp_code(x, w, 100) : 2'b00;
      check($sformatf("code_x%0d", x), 32'(cursor_code), 32'(e));
      check($sformatf("on_x%0d", x), 32'(cursor_on), 32'(e != 2'b00));
    end
    pixel_active = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_start = 1'b0;
    line_start = 1'b0;
    xpos = '0;
    ypos = '0;
    pixel_active = 1'b0;
    cursor_x = '0;
    cursor_y = '0;
    cursor_shape = '0;
    cursor_visible = 1'b0;
    tick();
    tick();
    check("rst_addr", 32'(rom_address), 32'd0);
    check("rst_on", 32'(cursor_on), 32'd0);
    check("rst_code", 32'(cursor_code), 32'd0);
    reset = 1'b0;
    tick();

    // basic fetch of shape 1 row 0, then line sweep
    new_frame(11'd100, 10'd50, 4'd1, 1'b1);
    ypos = 10'd49;
    line_start = 1'b1;
    tick();
    check("addr_hi", 32'(rom_address), 32'd32);
    line_start = 1'b0;
    tick();
    check("addr_lo", 32'(rom_address), 32'd33);
    tick();
    tick();
    ypos = 10'd50;
    sweep(98, 118, 32'hA020A021, 1'b1);
    check("live_1", dut.u_buf.live, 32'hA020A021);
    pixel_active = 1'b1;
    xpos = 11'd99;  tick(); check("px99", 32'(cursor_code), 32'd0);
    xpos = 11'd100; tick(); check("px100", 32'(cursor_code), 32'd2);
    xpos = 11'd105; tick(); check("px105", 32'(cursor_code), 32'd2);
    xpos = 11'd115; tick(); check("px115", 32'(cursor_code), 32'd1);
    xpos = 11'd116; tick(); check("px116", 32'(cursor_code), 32'd0);
    pixel_active = 1'b0;

    // cursor_x moved mid-frame is ignored
    new_frame(11'd100, 10'd50, 4'd1, 1'b1);
    cursor_x = 11'd200;
    ypos = 10'd49;
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick(); tick(); tick();
    pixel_active = 1'b1;
    xpos = 11'd100; tick(); check("midx_100", 32'(cursor_code), 32'd2);
    xpos = 11'd200; tick(); check("midx_200", 32'(cursor_code), 32'd0);
    pixel_active = 1'b0;

    // invisible cursor, then invalid shape
    new_frame(11'd100, 10'd50, 4'd1, 1'b0);
    ypos = 10'd49;
    line_start = 1'b1; tick(); line_start = 1'b0;
    check("inv_addr0", 32'(rom_address), 32'd33);
    tick(); tick(); tick();
    check("inv_addr3", 32'(rom_address), 32'd33);
    sweep(100, 115, 32'h0, 1'b0);
    new_frame(11'd100, 10'd50, 4'd12, 1'b1);
    ypos = 10'd49;
    line_start = 1'b1; tick(); line_start = 1'b0;
    check("shp_addr0", 32'(rom_address), 32'd33);
    tick(); tick(); tick();
    check("shp_addr3", 32'(rom_address), 32'd33);
    sweep(100, 115, 32'h0, 1'b0);

    // bottom clipping: rows 0..8 on lines 1015..1023
    new_frame(11'd100, 10'd1015, 4'd2, 1'b1);
    ypos = 10'd1013;
    line_start = 1'b1; tick(); line_start = 1'b0;
    check("bot_pre", 32'(rom_address), 32'd33);
    tick(); tick(); tick();
    for (int y = 1014; y <= 1022; y++) begin
      ypos = 10'(y);
      line_start = 1'b1;
      tick();
      line_start = 1'b0;
      check($sformatf("bot_hi%0d", y), 32'(rom_address),
            32'(64 + 2 * (y - 1014)));
      tick();
      check($sformatf("bot_lo%0d", y), 32'(rom_address),
            32'(65 + 2 * (y - 1014)));
      tick(); tick();
    end
    new_frame(11'd100, 10'd1015, 4'd2, 1'b1);
    for (int y = 0; y < 4; y++) begin
      ypos = 10'(y);
      line_start = 1'b1; tick(); line_start = 1'b0;
      tick(); tick(); tick();
      check($sformatf("wrap_y%0d", y), 32'(rom_address), 32'd81);
    end

    // restart: second line_start two cycles after the first
    new_frame(11'd100, 10'd50, 4'd1, 1'b1);
    ypos = 10'd49;
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    ypos = 10'd52;
    line_start = 1'b1; tick(); line_start = 1'b0;
    check("rs_hi", 32'(rom_address), 32'd38);
    tick();
    check("rs_lo", 32'(rom_address), 32'd39);
    tick(); tick();
    pixel_active = 1'b1;
    xpos = 11'd0;
    tick();
    pixel_active = 1'b0;
    check("rs_live", dut.u_buf.live, 32'hA026A027);

    // reset while in REQ_LO with the cursor being drawn
    pixel_active = 1'b1;
    xpos = 11'd100;
    ypos = 10'd49;
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick();
    check("pre_rst_on", 32'(cursor_on), 32'd1);
    check("pre_rst_addr", 32'(rom_address), 32'd33);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_addr", 32'(rom_address), 32'd0);
    check("rst_mid_on", 32'(cursor_on), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("post_rst_on", 32'(cursor_on), 32'd0);
    line_start = 1'b1; tick(); line_start = 1'b0;
    tick(); tick(); tick(); tick();
    check("post_rst_addr", 32'(rom_address), 32'd0);
    check("post_rst_on2", 32'(cursor_on), 32'd0);
    check("post_rst_live", dut.u_buf.live, 32'h0);
    pixel_active = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
